isi_channel_fir_param: RTL and testbench

Parametrised ISI channel model that succeeds the fixed 3-tap channel. It convolves the incoming signed symbol stream with a runtime-programmable pulse response of PULSE_RESPONSE_LENGTH taps. The result is saturated back to SIGNAL_RESOLUTION bits. It sits between the PAM transmitter/symbol generator and the receiver/equaliser in the SERDES simulation chain, and adds coefficient loading, history clear and bypass mode.

---
 rtl/isi_channel_fir_param_if.sv | 32 +++
 rtl/isi_channel_fir_param.sv | 103 ++++++++++
 tb/tb_isi_channel_fir_param.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/isi_channel_fir_param_if.sv
// Symbol stream, coefficient write port and control levels of the ISI channel model.
interface isi_channel_fir_param_if #(
   parameter int PULSE_RESPONSE_LENGTH = 3,
   parameter int SIGNAL_RESOLUTION     = 8,
   parameter int COEF_WIDTH            = 8
);
   localparam int ADDR_W = (PULSE_RESPONSE_LENGTH > 1) ? $clog2(PULSE_RESPONSE_LENGTH) : 1;

   // Streams are valid-only: no ready exists, so a symbol is consumed on every
   // cycle its valid is high and an output is presented for exactly one cycle.
   logic signed [SIGNAL_RESOLUTION-1:0] signal_in;
   logic                                signal_in_valid;
   logic signed [SIGNAL_RESOLUTION-1:0] signal_out;
   logic                                signal_out_valid;
   logic                                coef_wr_en;
   logic        [ADDR_W-1:0]            coef_wr_addr;
   logic signed [COEF_WIDTH-1:0]        coef_wr_data;
   logic                                hist_clr;
   logic                                bypass;

   modport master (
      output signal_in, signal_in_valid, coef_wr_en, coef_wr_addr, coef_wr_data,
             hist_clr, bypass,
      input  signal_out, signal_out_valid
   );

   modport slave (
      input  signal_in, signal_in_valid, coef_wr_en, coef_wr_addr, coef_wr_data,
             hist_clr, bypass,
      output signal_out, signal_out_valid
   );
endinterface

// File: rtl/isi_channel_fir_param.sv
// ISI channel model: symbol-indexed FIR with programmable pulse response,
// floor scaling by COEF_FRAC and saturation, two-cycle latency.
module isi_channel_fir_param #(
   parameter int PULSE_RESPONSE_LENGTH = 3,
   parameter int SIGNAL_RESOLUTION     = 8,
   parameter int COEF_WIDTH            = 8,
   parameter int COEF_FRAC             = 6
) (
   input logic                   clk,
   input logic                   rstn,
   isi_channel_fir_param_if.slave bus
);
   localparam int L  = PULSE_RESPONSE_LENGTH;
   localparam int RES = SIGNAL_RESOLUTION;
   localparam int CW = COEF_WIDTH;
   localparam int PW = RES + CW;
   localparam int SW = RES + CW + $clog2(L) + 1;

   localparam logic signed [SW-1:0] SAT_MAX  = SW'((1 << (RES - 1)) - 1);
   localparam logic signed [SW-1:0] SAT_MIN  = ~SAT_MAX;
   localparam logic signed [CW-1:0] COEF_ONE = CW'(1 << COEF_FRAC);

   logic signed [RES-1:0] hist      [L];
   logic signed [RES-1:0] hist_next [L];
   logic signed [CW-1:0]  coef      [L];
   logic signed [PW-1:0]  prod      [L];
   logic signed [RES-1:0] byp_val;
   logic                  byp_sel;
   logic                  s1_valid;
   logic signed [SW-1:0]  sum;
   logic signed [SW-1:0]  shifted;
   logic signed [RES-1:0] sat;
   logic signed [RES-1:0] out_q;
   logic                  out_valid_q;

   // History view including the incoming symbol; it also feeds the multipliers.
   always_comb begin
      for (int k = 0; k < L; k++) begin
         hist_next[k] = bus.hist_clr ? '0 : hist[k];
      end
      if (bus.signal_in_valid) begin
         hist_next[0] = bus.signal_in;
         for (int k = 1; k < L; k++) begin
            hist_next[k] = bus.hist_clr ? '0 : hist[k-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < L; k++) hist[k] <= '0;
      end else begin
         for (int k = 0; k < L; k++) hist[k] <= hist_next[k];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < L; k++) coef[k] <= (k == 0) ? COEF_ONE : '0;
      end else if (bus.coef_wr_en && (int'(bus.coef_wr_addr) < L)) begin
         coef[bus.coef_wr_addr] <= bus.coef_wr_data;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < L; k++) prod[k] <= '0;
         byp_val  <= '0;
         byp_sel  <= 1'b0;
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= bus.signal_in_valid;
         if (bus.signal_in_valid) begin
            for (int k = 0; k < L; k++) prod[k] <= PW'(hist_next[k]) * PW'(coef[k]);
            byp_val <= bus.signal_in;
            byp_sel <= bus.bypass;
         end
      end
   end

   // Arithmetic shift floors toward minus infinity; no rounding term is added.
   always_comb begin
      sum = '0;
      for (int k = 0; k < L; k++) sum = sum + SW'(prod[k]);
      shifted = sum >>> COEF_FRAC;
      if (shifted > SAT_MAX)      sat = SAT_MAX[RES-1:0];
      else if (shifted < SAT_MIN) sat = SAT_MIN[RES-1:0];
      else                        sat = shifted[RES-1:0];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= s1_valid;
         if (s1_valid) out_q <= byp_sel ? byp_val : sat;
      end
   end

   assign bus.signal_out       = out_q;
   assign bus.signal_out_valid = out_valid_q;
endmodule

// File: tb/tb_isi_channel_fir_param.sv
// Directed bench for isi_channel_fir_param: vector table plus hand-written
// sequences for latency, write ordering, bypass and mid-stream reset.
module tb_isi_channel_fir_param;
   localparam int L   = 3;
   localparam int RES = 8;
   localparam int CW  = 8;

   typedef struct {
      logic               load;
      logic               vld;
      logic               clr;
      logic               byp;
      logic signed [7:0]  din;
      logic signed [7:0]  exp;
      logic signed [7:0]  c0;
      logic signed [7:0]  c1;
      logic signed [7:0]  c2;
   } vec_t;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   isi_channel_fir_param_if #(.PULSE_RESPONSE_LENGTH(L), .SIGNAL_RESOLUTION(RES),
                              .COEF_WIDTH(CW)) bus();

   isi_channel_fir_param #(.PULSE_RESPONSE_LENGTH(L), .SIGNAL_RESOLUTION(RES),
                           .COEF_WIDTH(CW), .COEF_FRAC(6)) dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;
   int pushed = 0;
   int seen   = 0;
   logic [RES-1:0] exp_q[$];
   logic signed [RES-1:0] mon_exp;
   vec_t vecs[$];

   task automatic check(input string name, input logic signed [31:0] act,
                        input logic signed [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // Scoreboard: every output pulse consumes one expected sample in order.
   always @(negedge clk) begin
      if (rstn && bus.signal_out_valid) begin
         seen++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got out %0d, required no output", bus.signal_out);
         end else begin
            mon_exp = exp_q.pop_front();
            check($sformatf("out#%0d", seen), bus.signal_out, mon_exp);
         end
      end
   end

   task automatic idle_inputs();
      bus.signal_in       = '0;
      bus.signal_in_valid = 1'b0;
      bus.coef_wr_en      = 1'b0;
      bus.coef_wr_addr    = '0;
      bus.coef_wr_data    = '0;
      bus.hist_clr        = 1'b0;
      bus.bypass          = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic vld, input logic clr, input logic byp,
                        input logic signed [7:0] din, input logic push,
                        input logic signed [7:0] e);
      bus.signal_in_valid = vld;
      bus.hist_clr        = clr;
      bus.bypass          = byp;
      bus.signal_in       = din;
      if (vld && push) begin
         exp_q.push_back(e);
         pushed++;
      end
      tick();
      idle_inputs();
   endtask

   task automatic write_coef(input logic [1:0] a, input logic signed [7:0] d);
      bus.coef_wr_en   = 1'b1;
      bus.coef_wr_addr = a;
      bus.coef_wr_data = d;
      tick();
      idle_inputs();
   endtask

   task automatic load(input logic signed [7:0] c0, input logic signed [7:0] c1,
                       input logic signed [7:0] c2);
      write_coef(2'd0, c0);
      write_coef(2'd1, c1);
      write_coef(2'd2, c2);
      bus.hist_clr = 1'b1;
      tick();
      idle_inputs();
   endtask

   function automatic vec_t mk_load(input logic signed [7:0] c0, input logic signed [7:0] c1,
                                    input logic signed [7:0] c2);
      vec_t v = '{load: 1'b1, vld: 1'b0, clr: 1'b0, byp: 1'b0, din: '0, exp: '0,
                  c0: c0, c1: c1, c2: c2};
      return v;
   endfunction

   function automatic vec_t mk_data(input logic signed [7:0] din, input logic signed [7:0] e,
                                    input logic clr);
      vec_t v = '{load: 1'b0, vld: 1'b1, clr: clr, byp: 1'b0, din: din, exp: e,
                  c0: '0, c1: '0, c2: '0};
      return v;
   endfunction

   function automatic vec_t mk_idle();
      vec_t v = '{load: 1'b0, vld: 1'b0, clr: 1'b0, byp: 1'b0, din: '0, exp: '0,
                  c0: '0, c1: '0, c2: '0};
      return v;
   endfunction

   initial begin
      idle_inputs();
      // impulse response
      vecs.push_back(mk_load(64, 32, -16));
      vecs.push_back(mk_data(64, 64, 0));
      vecs.push_back(mk_data(0, 32, 0));
      vecs.push_back(mk_data(0, -16, 0));
      vecs.push_back(mk_data(0, 0, 0));
      // saturation on both rails
      vecs.push_back(mk_load(64, 64, 64));
      vecs.push_back(mk_data(100, 100, 0));
      vecs.push_back(mk_data(100, 127, 0));
      vecs.push_back(mk_data(100, 127, 0));
      vecs.push_back(mk_data(-128, 72, 0));
      vecs.push_back(mk_data(-128, -128, 0));
      vecs.push_back(mk_data(-128, -128, 0));
      // floor truncation with idle gaps
      vecs.push_back(mk_load(32, 0, 0));
      vecs.push_back(mk_data(-1, -1, 0));
      vecs.push_back(mk_idle());
      vecs.push_back(mk_idle());
      vecs.push_back(mk_idle());
      vecs.push_back(mk_data(1, 0, 0));
      vecs.push_back(mk_idle());
      vecs.push_back(mk_idle());
      vecs.push_back(mk_idle());
      // idle cycles must not shift the history
      vecs.push_back(mk_load(0, 64, 0));
      vecs.push_back(mk_data(5, 0, 0));
      vecs.push_back(mk_idle());
      vecs.push_back(mk_idle());
      vecs.push_back(mk_idle());
      vecs.push_back(mk_data(9, 5, 0));
      // history clear together with a valid input
      vecs.push_back(mk_load(64, 64, 0));
      vecs.push_back(mk_data(20, 20, 0));
      vecs.push_back(mk_data(20, 40, 0));
      vecs.push_back(mk_data(20, 20, 1));

      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_out", bus.signal_out, 0);
      check("reset_valid", bus.signal_out_valid, 0);
      @(negedge clk);
      rstn = 1'b1;

      // identity channel and exact two-cycle latency
      drive(1, 0, 0, 10, 1, 10);
      check("lat_valid_n1", bus.signal_out_valid, 0);
      drive(1, 0, 0, -5, 1, -5);
      check("lat_valid_n2", bus.signal_out_valid, 1);
      check("lat_out_n2", bus.signal_out, 10);
      drive(1, 0, 0, 127, 1, 127);
      repeat (2) tick();

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].load) load(vecs[i].c0, vecs[i].c1, vecs[i].c2);
         else              drive(vecs[i].vld, vecs[i].clr, vecs[i].byp, vecs[i].din, 1'b1,
                                 vecs[i].exp);
      end

      // out-of-range write ignored; same-cycle write uses the old coefficient
      write_coef(2'd3, -64);
      bus.coef_wr_en   = 1'b1;
      bus.coef_wr_addr = 2'd0;
      bus.coef_wr_data = 8'sd0;
      drive(1, 0, 0, 10, 1, 30);
      drive(1, 0, 0, 10, 1, 10);
      // bypass passes the symbol through but the history keeps shifting
      drive(1, 0, 1, 7, 1, 7);
      drive(1, 0, 0, 3, 1, 7);
      repeat (3) tick();
      check("hold_valid", bus.signal_out_valid, 0);
      check("hold_out", bus.signal_out, 7);

      // reset while a symbol is in flight
      drive(1, 0, 0, 50, 0, 0);
      #2;
      rstn = 1'b0;
      #1;
      check("midrst_out", bus.signal_out, 0);
      check("midrst_valid", bus.signal_out_valid, 0);
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      drive(1, 0, 0, 10, 1, 10);
      drive(1, 0, 0, -20, 1, -20);

      repeat (4) tick();
      check("drain_queue", exp_q.size(), 0);
      check("pulse_count", seen, pushed);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
